lbg_vq_distortion: RTL and testbench

- Parametrised successor to the LBG D1 distortion accumulator.
- For each MFCC frame it searches all 2^cw_log2 codewords for the nearest one by squared-Euclidean distance over DIM coefficients.
- It accumulates the minimum distances into a total distortion and streams a per-frame nearest-codeword index to the centroid-update stage.
- Sits between the MFCC13 frame RAM and codebook RAM and the LBG split/update controller.

---
 rtl/lbg_vq_distortion.sv | 203 ++++++++++++++++++++
 tb/tb_lbg_vq_distortion.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lbg_vq_distortion.sv
// Nearest-codeword search over MFCC frames: per frame, finds the codeword with the
// minimum squared-Euclidean distance, streams its index and accumulates the distortion.
module lbg_vq_distortion #(
  parameter int DIM         = 13,
  parameter int DW          = 14,
  parameter int MAX_CW_LOG2 = 4,
  parameter int FRAME_AW    = 9,
  parameter int FEAT_AW     = 13,
  parameter int CB_AW       = 8,
  parameter int ACC_W       = 48,
  parameter int RD_LAT      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   acc_mode,
  input  logic [FRAME_AW-1:0]    num_frames,
  input  logic [2:0]             cw_log2,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [FEAT_AW-1:0]     feat_rd_addr,
  input  logic [DW-1:0]          feat_rd_data,
  output logic [CB_AW-1:0]       cb_rd_addr,
  input  logic [DW-1:0]          cb_rd_data,
  output logic                   assign_valid,
  output logic [FRAME_AW-1:0]    assign_frame,
  output logic [MAX_CW_LOG2-1:0] assign_idx,
  output logic [ACC_W-1:0]       dist_total,
  output logic                   ovf
);

  localparam int DCNT_W = ($clog2(DIM) > 0) ? $clog2(DIM) : 1;
  localparam int LAT_W  = ($clog2(RD_LAT + 1) > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam int SUM_W  = 2 * DW + 2 + $clog2(DIM);
  localparam int ADD_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int K_W    = MAX_CW_LOG2 + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_CMP   = 3'd3,
    S_FRAME = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                  state_r, state_nx;
  logic [DCNT_W-1:0]       d_r;
  logic [LAT_W-1:0]        lat_r;
  logic [MAX_CW_LOG2-1:0]  k_r, min_idx_r;
  logic [FRAME_AW-1:0]     frame_r, nframes_r;
  logic [2:0]              cw_r;
  logic [SUM_W-1:0]        cw_sum_r, min_sum_r;
  logic [RD_LAT-1:0]       vld_r;
  logic signed [DW:0]      diff_s;
  logic signed [2*DW+1:0]  prod_s;
  logic [2*DW+1:0]         sq_s;
  logic [K_W-1:0]          last_k_s;
  logic [ADD_W-1:0]        sum_s;

  // Distance arithmetic and saturating-add operands
  always_comb begin
    diff_s   = $signed({feat_rd_data[DW-1], feat_rd_data}) - $signed({cb_rd_data[DW-1], cb_rd_data});
    prod_s   = diff_s * diff_s;
    sq_s     = $unsigned(prod_s);
    last_k_s = (K_W'(1) << cw_r) - K_W'(1);
    sum_s    = ADD_W'(dist_total) + ADD_W'(min_sum_r);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nx;
  end

  // FSM next-state logic; clear overrides every transition
  always_comb begin
    state_nx = state_r;
    case (state_r)
      S_IDLE: begin
        if (!start)                              state_nx = S_IDLE;
        else if (cw_log2 > 3'(MAX_CW_LOG2))      state_nx = S_DONE;
        else if (num_frames == '0)               state_nx = S_DONE;
        else                                     state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        if (d_r == DCNT_W'(DIM - 1)) state_nx = S_DRAIN;
        else                         state_nx = S_ISSUE;
      end
      S_DRAIN: begin
        if (lat_r == LAT_W'(RD_LAT - 1)) state_nx = S_CMP;
        else                             state_nx = S_DRAIN;
      end
      S_CMP: begin
        if ({1'b0, k_r} < last_k_s) state_nx = S_ISSUE;
        else                        state_nx = S_FRAME;
      end
      S_FRAME: begin
        if (frame_r == nframes_r - FRAME_AW'(1)) state_nx = S_DONE;
        else                                     state_nx = S_ISSUE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (clear) state_nx = S_IDLE;
    else       state_nx = state_nx;
  end

  // Datapath, counters, address generation and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r <= '0; lat_r <= '0; k_r <= '0; min_idx_r <= '0;
      frame_r <= '0; nframes_r <= '0; cw_r <= 3'd0;
      cw_sum_r <= '0; min_sum_r <= '0; vld_r <= '0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; ovf <= 1'b0;
      feat_rd_addr <= '0; cb_rd_addr <= '0;
      assign_valid <= 1'b0; assign_frame <= '0; assign_idx <= '0;
      dist_total <= '0;
    end else if (clear) begin
      d_r <= '0; lat_r <= '0; k_r <= '0; min_idx_r <= '0;
      frame_r <= '0; nframes_r <= '0; cw_r <= 3'd0;
      cw_sum_r <= '0; min_sum_r <= '0; vld_r <= '0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; ovf <= 1'b0;
      assign_valid <= 1'b0; assign_frame <= '0; assign_idx <= '0;
      dist_total <= '0;
    end else begin
      done         <= (state_nx == S_DONE);
      assign_valid <= 1'b0;
      busy         <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      // Returned-pair strobe: the issue strobe delayed by the RAM latency
      vld_r <= (vld_r << 1) | RD_LAT'(state_r == S_ISSUE);
      if (vld_r[RD_LAT-1]) cw_sum_r <= cw_sum_r + SUM_W'(sq_s);
      case (state_r)
        S_IDLE: begin
          if (start) begin
            nframes_r <= num_frames;
            cw_r      <= cw_log2;
            frame_r   <= '0;
            k_r       <= '0;
            d_r       <= '0;
            if (!acc_mode) begin
              dist_total <= '0;
              ovf        <= 1'b0;
            end
            if (cw_log2 > 3'(MAX_CW_LOG2)) err <= 1'b1;
            if (state_nx == S_ISSUE) begin
              feat_rd_addr <= '0;
              cb_rd_addr   <= '0;
              cw_sum_r     <= '0;
            end
          end
        end
        S_ISSUE: begin
          if (d_r == DCNT_W'(DIM - 1)) begin
            d_r   <= '0;
            lat_r <= '0;
          end else begin
            d_r          <= d_r + DCNT_W'(1);
            feat_rd_addr <= feat_rd_addr + FEAT_AW'(1);
            cb_rd_addr   <= cb_rd_addr + CB_AW'(1);
          end
        end
        S_DRAIN: lat_r <= lat_r + LAT_W'(1);
        S_CMP: begin
          if ((k_r == '0) || (cw_sum_r < min_sum_r)) begin
            min_sum_r <= cw_sum_r;
            min_idx_r <= k_r;
          end
          // Next codeword: rewind the feature pointer to the frame base
          if (state_nx == S_ISSUE) begin
            k_r          <= k_r + MAX_CW_LOG2'(1);
            feat_rd_addr <= feat_rd_addr - FEAT_AW'(DIM - 1);
            cb_rd_addr   <= cb_rd_addr + CB_AW'(1);
            cw_sum_r     <= '0;
          end
        end
        S_FRAME: begin
          if (|sum_s[ADD_W-1:ACC_W]) begin
            dist_total <= '1;
            ovf        <= 1'b1;
          end else begin
            dist_total <= sum_s[ACC_W-1:0];
          end
          assign_valid <= 1'b1;
          assign_frame <= frame_r;
          assign_idx   <= min_idx_r;
          k_r          <= '0;
          if (state_nx == S_ISSUE) begin
            frame_r      <= frame_r + FRAME_AW'(1);
            feat_rd_addr <= feat_rd_addr + FEAT_AW'(1);
            cb_rd_addr   <= '0;
            cw_sum_r     <= '0;
          end
        end
        S_DONE:  k_r <= '0;
        default: k_r <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lbg_vq_distortion.sv
// Scoreboard bench for lbg_vq_distortion: a plain-arithmetic nearest-codeword model
// predicts assignments and totals; a monitor compares every assign_valid pulse.
module tb_lbg_vq_distortion;
  localparam int DIM = 13;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0, clear = 1'b0, acc_mode = 1'b0;
  logic [8:0]         num_frames = '0;
  logic [2:0]         cw_log2 = '0;
  logic               busy, done, err, assign_valid, ovf;
  logic [12:0]        feat_rd_addr;
  logic [7:0]         cb_rd_addr;
  logic [13:0]        feat_rd_data = '0, cb_rd_data = '0;
  logic [8:0]         assign_frame;
  logic [3:0]         assign_idx;
  logic [47:0]        dist_total;

  // Narrow-accumulator instance for saturation
  logic               s_start = 1'b0, s_busy, s_done, s_err, s_av, s_ovf;
  logic [12:0]        s_faddr;
  logic [7:0]         s_caddr;
  logic [13:0]        s_fdata = '0, s_cdata = '0;
  logic [8:0]         s_aframe;
  logic [3:0]         s_aidx;
  logic [5:0]         s_dist;

  logic signed [13:0] feat_mem [0:8191];
  logic signed [13:0] cb_mem   [0:255];

  typedef struct { int frame; int idx; } exp_t;
  exp_t   exp_q[$];
  int     errors = 0, checks = 0, done_cnt = 0;
  longint exp_total = 0;
  int     exp_err = 0;

  always #5 clk = ~clk;

  lbg_vq_distortion dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .acc_mode(acc_mode),
    .num_frames(num_frames), .cw_log2(cw_log2), .busy(busy), .done(done), .err(err),
    .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
    .cb_rd_addr(cb_rd_addr), .cb_rd_data(cb_rd_data),
    .assign_valid(assign_valid), .assign_frame(assign_frame), .assign_idx(assign_idx),
    .dist_total(dist_total), .ovf(ovf)
  );

  lbg_vq_distortion #(.ACC_W(6)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .clear(1'b0), .acc_mode(1'b0),
    .num_frames(9'd2), .cw_log2(3'd0), .busy(s_busy), .done(s_done), .err(s_err),
    .feat_rd_addr(s_faddr), .feat_rd_data(s_fdata),
    .cb_rd_addr(s_caddr), .cb_rd_data(s_cdata),
    .assign_valid(s_av), .assign_frame(s_aframe), .assign_idx(s_aidx),
    .dist_total(s_dist), .ovf(s_ovf)
  );

  // RAM models with one cycle of read latency
  always @(posedge clk) begin
    feat_rd_data <= feat_mem[feat_rd_addr];
    cb_rd_data   <= cb_mem[cb_rd_addr];
    s_fdata      <= feat_mem[s_faddr];
    s_cdata      <= cb_mem[s_caddr];
  end

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: every assignment pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (assign_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL assign_unexpected: got frame %0d idx %0d expected no pulse", assign_frame, assign_idx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (assign_frame != 9'(e.frame) || assign_idx != 4'(e.idx)) begin
          errors++;
          $display("FAIL assign: got frame %0d idx %0d expected frame %0d idx %0d",
                   assign_frame, assign_idx, e.frame, e.idx);
        end
      end
    end
  end

  task automatic model_frame(input int f, input int cw, output int idx, output longint mn);
    longint s;
    int df;
    mn = 0; idx = 0;
    for (int k = 0; k < (1 << cw); k++) begin
      s = 0;
      for (int d = 0; d < DIM; d++) begin
        df = int'(feat_mem[f*DIM + d]) - int'(cb_mem[k*DIM + d]);
        s += longint'(df) * longint'(df);
      end
      if (k == 0 || s < mn) begin
        mn = s; idx = k;
      end
    end
  endtask

  task automatic set_feat(input int f, input int v);
    for (int d = 0; d < DIM; d++) feat_mem[f*DIM + d] = 14'(v);
  endtask

  task automatic set_cb(input int k, input int v);
    for (int d = 0; d < DIM; d++) cb_mem[k*DIM + d] = 14'(v);
  endtask

  task automatic run(input int nf, input int cw, input bit accm);
    int idx, n, lat;
    longint mn;
    bit valid_run;
    valid_run = (cw <= 4) && (nf > 0);
    if (!accm) exp_total = 0;
    if (cw > 4) exp_err = 1;
    if (valid_run) begin
      for (int f = 0; f < nf; f++) begin
        model_frame(f, cw, idx, mn);
        exp_q.push_back('{frame: f, idx: idx});
        exp_total += mn;
      end
    end
    lat = valid_run ? nf * ((1 << cw) * (DIM + 1 + 1) + 1) : 0;
    @(negedge clk);
    start = 1'b1; num_frames = 9'(nf); cw_log2 = 3'(cw); acc_mode = accm;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", longint'(busy), longint'(valid_run));
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("done_latency", done ? n : -1, lat);
    chk("dist_total", longint'(dist_total), exp_total);
    chk("err", longint'(err), exp_err);
    @(negedge clk);
    chk("done_one_cycle", longint'(done), 0);
    chk("assign_count", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int n, d0;
    logic [12:0] fa0;
    logic [7:0]  ca0;
    for (int i = 0; i < 8192; i++) feat_mem[i] = '0;
    for (int i = 0; i < 256; i++)  cb_mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_dist", longint'(dist_total), 0);
    chk("rst_err", longint'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_done", longint'(done), 0);
    chk("idle_assign", longint'(assign_valid), 0);
    chk("idle_addr", longint'(feat_rd_addr), 0);

    // Single codeword and accumulate mode
    set_feat(0, 3); set_feat(1, 3); set_cb(0, 1);
    run(1, 0, 1'b0);
    run(1, 0, 1'b1);
    chk("acc_104", longint'(dist_total), 104);
    run(1, 0, 1'b0);

    // Two codewords, positive then negative values
    set_cb(1, 2);
    run(1, 1, 1'b0);
    set_feat(0, -5); set_cb(0, 0); set_cb(1, -4);
    run(1, 1, 1'b0);

    // Ties keep the lowest index; then only cw15 matches exactly
    for (int k = 0; k < 16; k++) set_cb(k, 100);
    for (int f = 0; f < 3; f++) set_feat(f, 20 * f - 30);
    run(3, 4, 1'b0);
    for (int f = 0; f < 3; f++) set_feat(f, -777);
    set_cb(15, -777);
    run(3, 4, 1'b0);

    // Zero frames and unsupported codeword count
    run(0, 0, 1'b0);
    fa0 = feat_rd_addr; ca0 = cb_rd_addr;
    run(0, 5, 1'b1);
    chk("err_no_feat_read", longint'(feat_rd_addr), longint'(fa0));
    chk("err_no_cb_read", longint'(cb_rd_addr), longint'(ca0));

    // Abort mid-issue
    set_feat(0, 3); set_feat(1, 3); set_cb(0, 1);
    @(negedge clk);
    start = 1'b1; num_frames = 9'd2; cw_log2 = 3'd4; acc_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    d0 = done_cnt;
    chk("clear_busy", longint'(busy), 0);
    chk("clear_dist", longint'(dist_total), 0);
    chk("clear_err", longint'(err), 0);
    chk("clear_done", longint'(done), 0);
    exp_total = 0; exp_err = 0;
    repeat (300) @(negedge clk);
    chk("clear_no_done", done_cnt, d0);
    run(1, 0, 1'b1);

    // Randomised runs
    for (int r = 0; r < 5; r++) begin
      int nf, cw;
      nf = int'($urandom_range(1, 5));
      cw = int'($urandom_range(0, 4));
      for (int i = 0; i < nf * DIM; i++) feat_mem[i] = 14'($urandom_range(0, 16383));
      for (int i = 0; i < 16 * DIM; i++) cb_mem[i] = 14'($urandom_range(0, 16383));
      run(nf, cw, 1'($urandom_range(0, 1)));
    end

    // Saturation on the 6-bit accumulator instance
    set_feat(0, 3); set_feat(1, 3); set_cb(0, 1);
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (!s_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("sat_done", longint'(s_done), 1);
    chk("sat_dist", longint'(s_dist), 63);
    chk("sat_ovf", longint'(s_ovf), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
